// File: rtl/fll_lock_ctrl_pkg.sv
// Shared types and constants for the FLL lock controller and its sub-blocks.
package fll_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SAR    = 3'd1,
        ST_TRACK  = 3'd2,
        ST_LOCKED = 3'd3,
        ST_FAULT  = 3'd4
    } fll_state_e;

    localparam logic [2:0] CORNER_MAX = 3'b100;
    localparam logic [2:0] CORNER_NOM = 3'b010;
    localparam logic [2:0] CORNER_MIN = 3'b001;

endpackage

// File: rtl/fll_lock_ctrl_if.sv
// Measurement handshake, band limits and status between the FLL sequencer and its surroundings.
interface fll_lock_ctrl_if #(
    parameter int N  = 32,
    parameter int CW = 9
);
    logic          enable;
    logic [N-1:0]  lower_bound;
    logic [N-1:0]  upper_bound;
    logic [N-1:0]  meas_count;
    logic          meas_valid;
    logic          meas_start;
    logic [CW-1:0] code;
    logic          locked;
    logic [2:0]    corner;
    logic [2:0]    state;
    logic          fault;

    modport master (
        input  enable, lower_bound, upper_bound, meas_count, meas_valid,
        output meas_start, code, locked, corner, state, fault
    );

    modport slave (
        output enable, lower_bound, upper_bound, meas_count, meas_valid,
        input  meas_start, code, locked, corner, state, fault
    );
endinterface

// File: rtl/fll_band_cmp.sv
// Classifies a measured DCO count against an inclusive [lower, upper] band.
module fll_band_cmp #(
    parameter int N = 32
) (
    input  logic [N-1:0] i_count,
    input  logic [N-1:0] i_lower,
    input  logic [N-1:0] i_upper,
    output logic         o_slow,
    output logic         o_fast,
    output logic         o_inband
);
    // With an inverted band a count can be both slow and fast; it is never inband.
    assign o_slow   = i_count < i_lower;
    assign o_fast   = i_count > i_upper;
    assign o_inband = !o_slow && !o_fast;
endmodule

// File: rtl/fll_lock_ctrl.sv
// FLL sequencer: SAR search over the DCO code, then single-LSB tracking and lock detection.
// Define FLL_TIMEOUT_EN to add the meas_valid watchdog and the FAULT state.
module fll_lock_ctrl
    import fll_pkg::*;
#(
    parameter int N        = 32,
    parameter int CW       = 9,
    parameter int LOCK_CNT = 4,
    parameter int TIMEOUT  = 1024
) (
    input  logic           clk_ref,
    input  logic           reset,
    fll_lock_ctrl_if.master bus
);
    localparam int BW  = (CW > 1) ? $clog2(CW) : 1;
    localparam int LCW = $clog2(LOCK_CNT + 1);
    localparam logic [CW-1:0] CODE_MID = CW'(1) << (CW - 1);

    fll_state_e     r_state, w_state;
    logic           r_wait, w_wait;
    logic [CW-1:0]  r_code, w_code;
    logic           r_locked, w_locked;
    logic [2:0]     r_corner, w_corner;
    logic           r_meas_start, w_meas_start;
    logic [BW-1:0]  r_bit, w_bit;
    logic [LCW-1:0] r_cnt, w_cnt;
    logic [CW-1:0]  w_bit_mask;
    logic           w_slow, w_fast, w_inband, w_dn;

    fll_band_cmp #(.N(N)) u_band_cmp (
        .i_count  (bus.meas_count),
        .i_lower  (bus.lower_bound),
        .i_upper  (bus.upper_bound),
        .o_slow   (w_slow),
        .o_fast   (w_fast),
        .o_inband (w_inband)
    );

    // Slow wins when both flags are set, so an inverted band steps the code up.
    assign w_dn = w_fast && !w_slow;

`ifdef FLL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] r_tmo, w_tmo;
    logic          r_fault, w_fault;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT;
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        w_state      = r_state;
        w_wait       = r_wait;
        w_code       = r_code;
        w_locked     = r_locked;
        w_corner     = r_corner;
        w_meas_start = 1'b0;
        w_bit        = r_bit;
        w_cnt        = r_cnt;
        w_bit_mask   = CW'(1) << r_bit;
`ifdef FLL_TIMEOUT_EN
        w_tmo        = r_tmo;
        w_fault      = r_fault;
`endif
        if (!bus.enable) begin
            w_state  = ST_IDLE;
            w_wait   = 1'b0;
            w_locked = 1'b0;
`ifdef FLL_TIMEOUT_EN
            w_fault  = 1'b0;
`endif
        end else if (r_state == ST_IDLE) begin
            w_state = ST_SAR;
            w_wait  = 1'b0;
            w_code  = CODE_MID;
            w_bit   = BW'(CW - 1);
            w_cnt   = '0;
        end else if (r_state == ST_FAULT) begin
            w_state = ST_FAULT;
        end else if (!r_wait) begin
            w_meas_start = 1'b1;
            w_wait       = 1'b1;
`ifdef FLL_TIMEOUT_EN
            w_tmo        = '0;
`endif
        end else if (bus.meas_valid) begin
            w_wait = 1'b0;
            if (r_state == ST_SAR) begin
                if (w_inband) begin
                    w_state = ST_TRACK;
                end else begin
                    w_code = w_dn ? (r_code & ~w_bit_mask) : r_code;
                    if (r_bit != '0) begin
                        w_code = w_code | (w_bit_mask >> 1);
                        w_bit  = r_bit - 1'b1;
                    end else begin
                        w_state = ST_TRACK;
                    end
                end
            end else if (w_inband) begin
                if (r_state == ST_TRACK) begin
                    w_cnt = r_cnt + 1'b1;
                    if (r_cnt == LCW'(LOCK_CNT - 1)) begin
                        w_state  = ST_LOCKED;
                        w_locked = 1'b1;
                    end
                end
            end else begin
                // Out of band in TRACK or LOCKED: one LSB step, saturating at the code range ends.
                w_state  = ST_TRACK;
                w_locked = 1'b0;
                w_cnt    = '0;
                if (!w_dn) begin
                    if (r_code == '1) begin
                        w_corner = CORNER_MAX;
                    end else begin
                        w_code   = r_code + 1'b1;
                        w_corner = CORNER_NOM;
                    end
                end else begin
                    if (r_code == '0) begin
                        w_corner = CORNER_MIN;
                    end else begin
                        w_code   = r_code - 1'b1;
                        w_corner = CORNER_NOM;
                    end
                end
            end
        end
`ifdef FLL_TIMEOUT_EN
        else if (r_tmo == TW'(TIMEOUT - 1)) begin
            w_state  = ST_FAULT;
            w_wait   = 1'b0;
            w_locked = 1'b0;
            w_fault  = 1'b1;
        end else begin
            w_tmo = r_tmo + 1'b1;
        end
`endif
    end

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_ref) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_wait       <= 1'b0;
            r_code       <= CODE_MID;
            r_locked     <= 1'b0;
            r_corner     <= CORNER_NOM;
            r_meas_start <= 1'b0;
            r_bit        <= BW'(CW - 1);
            r_cnt        <= '0;
`ifdef FLL_TIMEOUT_EN
            r_tmo        <= '0;
            r_fault      <= 1'b0;
`endif
        end else begin
            r_state      <= w_state;
            r_wait       <= w_wait;
            r_code       <= w_code;
            r_locked     <= w_locked;
            r_corner     <= w_corner;
            r_meas_start <= w_meas_start;
            r_bit        <= w_bit;
            r_cnt        <= w_cnt;
`ifdef FLL_TIMEOUT_EN
            r_tmo        <= w_tmo;
            r_fault      <= w_fault;
`endif
        end
    end

    assign bus.meas_start = r_meas_start;
    assign bus.code       = r_code;
    assign bus.locked     = r_locked;
    assign bus.corner     = r_corner;
    assign bus.state      = r_state;
`ifdef FLL_TIMEOUT_EN
    assign bus.fault      = r_fault;
`else
    assign bus.fault      = 1'b0;
`endif
endmodule

// File: tb/tb_fll_lock_ctrl.sv
// Directed bench for fll_lock_ctrl: SAR lock, saturation, lock loss, abort, reset and (optionally) timeout.
module tb_fll_lock_ctrl;
    import fll_pkg::*;

    localparam int N        = 32;
    localparam int CW       = 9;
    localparam int LOCK_CNT = 3;
    localparam int TIMEOUT  = 16;

    logic clk_ref = 1'b0;
    logic reset   = 1'b1;

    fll_lock_ctrl_if #(.N(N), .CW(CW)) bus ();

    fll_lock_ctrl #(.N(N), .CW(CW), .LOCK_CNT(LOCK_CNT), .TIMEOUT(TIMEOUT)) dut (
        .clk_ref (clk_ref),
        .reset   (reset),
        .bus     (bus.master)
    );

    always #5 clk_ref = ~clk_ref;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] cnt;
        logic [8:0]  code;
        fll_state_e  st;
        logic        locked;
    } vec_t;

    vec_t        vec [11];
    logic [8:0]  exp_max [9];
    logic [8:0]  exp_min [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        bus.meas_valid = 1'b0;
        repeat (2) @(negedge clk_ref);
        reset = 1'b0;
    endtask

    task automatic wait_start(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_ref);
            if (bus.meas_start) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s: no meas_start within 40 cycles", name);
        end
    endtask

    // Returns a count 5 cycles after meas_start; the DUT reacts on the following edge.
    task automatic deliver(input logic [31:0] cnt);
        repeat (5) @(negedge clk_ref);
        bus.meas_count = cnt;
        bus.meas_valid = 1'b1;
        @(negedge clk_ref);
        bus.meas_valid = 1'b0;
    endtask

    task automatic meas_auto(input string name, input int mult, input logic [31:0] fixed, output bit ok);
        wait_start(name, ok);
        if (ok) deliver((mult == 0) ? fixed : 32'(mult) * 32'(bus.code));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit ok;
        int seen;

        vec[0]  = '{32'd1024, 9'd256, ST_SAR,    1'b0};
        vec[1]  = '{32'd512,  9'd128, ST_SAR,    1'b0};
        vec[2]  = '{32'd768,  9'd192, ST_SAR,    1'b0};
        vec[3]  = '{32'd896,  9'd224, ST_SAR,    1'b0};
        vec[4]  = '{32'd960,  9'd240, ST_SAR,    1'b0};
        vec[5]  = '{32'd992,  9'd248, ST_SAR,    1'b0};
        vec[6]  = '{32'd1008, 9'd252, ST_SAR,    1'b0};
        vec[7]  = '{32'd1008, 9'd252, ST_TRACK,  1'b0};
        vec[8]  = '{32'd1008, 9'd252, ST_TRACK,  1'b0};
        vec[9]  = '{32'd1008, 9'd252, ST_TRACK,  1'b0};
        vec[10] = '{32'd1260, 9'd252, ST_LOCKED, 1'b1};
        exp_max = '{9'd256, 9'd384, 9'd448, 9'd480, 9'd496, 9'd504, 9'd508, 9'd510, 9'd511};
        exp_min = '{9'd256, 9'd128, 9'd64, 9'd32, 9'd16, 9'd8, 9'd4, 9'd2, 9'd1};

        bus.enable      = 1'b0;
        bus.lower_bound = 32'd1000;
        bus.upper_bound = 32'd1010;
        bus.meas_count  = '0;
        bus.meas_valid  = 1'b0;

        do_reset();
        check("rst_code",   bus.code,       32'd256);
        check("rst_locked", bus.locked,     32'd0);
        check("rst_corner", bus.corner,     32'(CORNER_NOM));
        check("rst_start",  bus.meas_start, 32'd0);
        check("rst_state",  bus.state,      32'(ST_IDLE));
        check("rst_fault",  bus.fault,      32'd0);

        // SAR search then lock at 252, then a fast result at lock.
        bus.enable = 1'b1;
        @(negedge clk_ref);
        check("enter_sar_state", bus.state,      32'(ST_SAR));
        check("enter_sar_start", bus.meas_start, 32'd0);
        for (int i = 0; i < 11; i++) begin
            wait_start($sformatf("vec%0d_start", i), ok);
            if (!ok) break;
            check($sformatf("vec%0d_code", i),   bus.code,   32'(vec[i].code));
            check($sformatf("vec%0d_state", i),  bus.state,  32'(vec[i].st));
            check($sformatf("vec%0d_locked", i), bus.locked, 32'(vec[i].locked));
            deliver(vec[i].cnt);
        end
        check("loss_locked", bus.locked, 32'd0);
        check("loss_code",   bus.code,   32'd251);
        check("loss_state",  bus.state,  32'(ST_TRACK));

        // Walk down with count = 5*code until 202 (1010, upper bound inclusive), then relock.
        for (int k = 0; k < 60 && bus.code != 9'd202; k++) begin
            meas_auto("walk", 5, 0, ok);
            if (!ok) break;
        end
        check("walk_code",   bus.code,   32'd202);
        check("walk_locked", bus.locked, 32'd0);
        for (int k = 0; k < 3; k++) begin
            meas_auto("relock", 5, 0, ok);
            if (k < 2) check($sformatf("relock%0d_locked", k), bus.locked, 32'd0);
        end
        check("relock_locked", bus.locked, 32'd1);
        check("relock_state",  bus.state,  32'(ST_LOCKED));
        check("relock_code",   bus.code,   32'd202);

        // Abort during a wait phase; both late results must be ignored.
        wait_start("abort_start", ok);
        repeat (2) @(negedge clk_ref);
        bus.enable     = 1'b0;
        bus.meas_count = 32'd5000;
        bus.meas_valid = 1'b1;
        @(negedge clk_ref);
        bus.meas_valid = 1'b0;
        check("abort_state",  bus.state,  32'(ST_IDLE));
        check("abort_code",   bus.code,   32'd202);
        check("abort_locked", bus.locked, 32'd0);
        @(negedge clk_ref);
        bus.meas_valid = 1'b1;
        @(negedge clk_ref);
        bus.meas_valid = 1'b0;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_ref);
            if (bus.meas_start) seen++;
        end
        check("abort_code2",   bus.code,  32'd202);
        check("abort_state2",  bus.state, 32'(ST_IDLE));
        check("abort_nostart", 32'(seen), 32'd0);

        // Min saturation: every result fast.
        bus.enable = 1'b1;
        for (int k = 0; k < 9; k++) begin
            wait_start("min_start", ok);
            if (!ok) break;
            check($sformatf("min%0d_code", k), bus.code, 32'(exp_min[k]));
            deliver(32'd50000);
        end
        check("min_sar_code",  bus.code,  32'd0);
        check("min_sar_state", bus.state, 32'(ST_TRACK));
        meas_auto("min_sat", 0, 32'd50000, ok);
        check("min_sat_code",   bus.code,   32'd0);
        check("min_sat_corner", bus.corner, 32'(CORNER_MIN));

        // Reset mid-operation restores reset values.
        bus.enable = 1'b0;
        do_reset();
        check("midrst_code",   bus.code,   32'd256);
        check("midrst_corner", bus.corner, 32'(CORNER_NOM));
        check("midrst_state",  bus.state,  32'(ST_IDLE));

        // Max saturation: every result slow (count fixed at 10).
        bus.enable = 1'b1;
        for (int k = 0; k < 9; k++) begin
            wait_start("max_start", ok);
            if (!ok) break;
            check($sformatf("max%0d_code", k), bus.code, 32'(exp_max[k]));
            deliver(32'd10);
        end
        check("max_sar_code",  bus.code,  32'd511);
        check("max_sar_state", bus.state, 32'(ST_TRACK));
        meas_auto("max_sat", 0, 32'd10, ok);
        check("max_sat_code",   bus.code,   32'd511);
        check("max_sat_corner", bus.corner, 32'(CORNER_MAX));
        check("max_sat_locked", bus.locked, 32'd0);

`ifdef FLL_TIMEOUT_EN
        // Withhold meas_valid: FAULT after TIMEOUT wait cycles.
        bus.enable = 1'b0;
        @(negedge clk_ref);
        bus.enable = 1'b1;
        wait_start("tmo_start", ok);
        repeat (TIMEOUT - 1) @(negedge clk_ref);
        check("tmo_fault_early", bus.fault, 32'd0);
        @(negedge clk_ref);
        check("tmo_fault", bus.fault,  32'd1);
        check("tmo_state", bus.state,  32'(ST_FAULT));
        check("tmo_locked", bus.locked, 32'd0);
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_ref);
            if (bus.meas_start) seen++;
        end
        check("tmo_nostart", 32'(seen), 32'd0);
        bus.enable = 1'b0;
        @(negedge clk_ref);
        check("tmo_exit_state", bus.state, 32'(ST_IDLE));
        check("tmo_exit_fault", bus.fault, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
